// File: rtl/regfile_sb.sv
//============================================================================
// Module   : regfile_sb
// Brief    : Parametrised register file with per-register busy scoreboard.
//            Optional writeback-to-read bypass: define REGFILE_SB_BYPASS_EN.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [NRD*AW-1:0]   rs_idx,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  output logic [AW:0]         busy_count
);

  localparam logic [AW-1:0] c_zero_idx = '0;

  logic [XLEN-1:0]  r_mem [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic [AW:0]      r_busy_count;

  logic w_wb_en;
  logic w_iss_en;
  logic w_same_rd;
  logic w_set;
  logic w_clr;

  // Register 0 is hard-wired: never written, never busy.
  assign w_wb_en   = wb_valid    && !stall && (wb_rd    != c_zero_idx);
  assign w_iss_en  = issue_valid && !stall && (issue_rd != c_zero_idx);
  assign w_same_rd = w_iss_en && w_wb_en && (issue_rd == wb_rd);

  // Issue is applied after writeback so a same-register collision ends busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wb_en) begin
      w_busy_nxt[wb_rd] = 1'b0;
    end
    if (w_iss_en) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Population count tracked incrementally from the bits that actually flip.
  assign w_set = w_iss_en && !r_busy[issue_rd];
  assign w_clr = w_wb_en && r_busy[wb_rd] && !w_same_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy       <= '0;
      r_busy_count <= '0;
    end else if (!stall) begin
      r_busy <= w_busy_nxt;
      case ({w_set, w_clr})
        2'b10:   r_busy_count <= r_busy_count + 1'b1;
        2'b01:   r_busy_count <= r_busy_count - 1'b1;
        default: r_busy_count <= r_busy_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wb_en) begin
      r_mem[wb_rd] <= wb_data;
    end
  end

  assign busy_count = r_busy_count;

  for (genvar k = 0; k < NRD; k++) begin : g_rd_port
    logic [AW-1:0]   w_idx;
    logic [XLEN-1:0] w_arr_data;
    logic            w_arr_busy;

    assign w_idx      = rs_idx[k*AW +: AW];
    assign w_arr_data = (w_idx == c_zero_idx) ? '0 : r_mem[w_idx];
    assign w_arr_busy = r_busy[w_idx];

`ifdef REGFILE_SB_BYPASS_EN
    logic w_fwd;

    // A colliding issue keeps the pre-edge busy bit; data is still forwarded.
    assign w_fwd                    = w_wb_en && !reset && (w_idx == wb_rd);
    assign rs_data[k*XLEN +: XLEN]  = w_fwd ? wb_data : w_arr_data;
    assign rs_busy[k]               = (w_fwd && !w_same_rd) ? 1'b0 : w_arr_busy;
`else
    assign rs_data[k*XLEN +: XLEN]  = w_arr_data;
    assign rs_busy[k]               = w_arr_busy;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
//============================================================================
// Module   : tb_regfile_sb
// Brief    : Directed vector bench for regfile_sb (two read ports, 32x32).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_regfile_sb;

`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [9:0]  rs_idx;
  logic [63:0] rs_data;
  logic [1:0]  rs_busy;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [5:0]  busy_count;

  regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .rs_idx      (rs_idx),
    .rs_data     (rs_data),
    .rs_busy     (rs_busy),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .busy_count  (busy_count)
  );

  always #5 clk = ~clk;

  // Expectations describe outputs after inputs settle, before the vector's edge.
  typedef struct {
    logic        stall;
    logic [4:0]  i0, i1;
    logic        iv;
    logic [4:0]  ird;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic [31:0] ed0;
    logic        eb0;
    logic [31:0] ed1;
    logic        eb1;
    logic [5:0]  ecnt;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic st, input logic [4:0] i0, input logic [4:0] i1,
                              input logic iv, input logic [4:0] ird,
                              input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                              input logic [31:0] ed0, input logic eb0,
                              input logic [31:0] ed1, input logic eb1, input logic [5:0] ecnt);
    vec_t v;
    v.stall = st; v.i0 = i0; v.i1 = i1; v.iv = iv; v.ird = ird;
    v.wv = wv; v.wrd = wrd; v.wd = wd;
    v.ed0 = ed0; v.eb0 = eb0; v.ed1 = ed1; v.eb1 = eb1; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int tag, input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %h, want %h", nm, tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [4:0] i0, input logic [4:0] i1,
                       input logic iv, input logic [4:0] ird,
                       input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
    stall = st; rs_idx = {i1, i0};
    issue_valid = iv; issue_rd = ird;
    wb_valid = wv; wb_rd = wrd; wb_data = wd;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    idle();

    tbl[0]  = mk(0, 0, 31, 0, 0, 0, 0, 32'h0,         32'h0, 0, 32'h0, 0, 0);
    tbl[1]  = mk(0, 17, 5, 1, 5, 0, 0, 32'h0,         32'h0, 0, 32'h0, 0, 0);
    tbl[2]  = mk(0, 5, 0, 0, 0, 1, 5, 32'hDEADBEEF,
                 BYP ? 32'hDEADBEEF : 32'h0, !BYP, 32'h0, 0, 1);
    tbl[3]  = mk(0, 5, 5, 1, 0, 1, 0, 32'h1234,       32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0);
    tbl[4]  = mk(0, 0, 5, 0, 0, 0, 0, 32'h0,          32'h0, 0, 32'hDEADBEEF, 0, 0);
    tbl[5]  = mk(0, 7, 0, 1, 7, 1, 7, 32'h55,
                 BYP ? 32'h55 : 32'h0, 0, 32'h0, 0, 0);
    tbl[6]  = mk(1, 7, 4, 1, 3, 1, 4, 32'hAA,         32'h55, 1, 32'h0, 0, 1);
    tbl[7]  = mk(0, 3, 4, 0, 0, 0, 0, 32'h0,          32'h0, 0, 32'h0, 0, 1);
    tbl[8]  = mk(0, 3, 4, 1, 3, 1, 4, 32'hAA,
                 32'h0, 0, BYP ? 32'hAA : 32'h0, 0, 1);
    tbl[9]  = mk(0, 3, 4, 0, 0, 0, 0, 32'h0,          32'h0, 1, 32'hAA, 0, 2);
    tbl[10] = mk(0, 3, 7, 1, 7, 1, 3, 32'h33,
                 BYP ? 32'h33 : 32'h0, !BYP, 32'h55, 1, 2);
    tbl[11] = mk(0, 3, 7, 0, 0, 0, 0, 32'h0,          32'h33, 0, 32'h55, 1, 1);
    tbl[12] = mk(0, 7, 7, 0, 0, 1, 7, 32'h77,
                 BYP ? 32'h77 : 32'h55, !BYP, BYP ? 32'h77 : 32'h55, !BYP, 1);

    // Reset, then sweep every index on both ports.
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'(i), 5'(31 - i), 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
      #1;
      n_vec++;
      chk("rst_data0", i, rs_data[31:0], 32'h0);
      chk("rst_data1", i, rs_data[63:32], 32'h0);
      chk("rst_busy", i, {30'h0, rs_busy}, 32'h0);
      chk("rst_cnt", i, {26'h0, busy_count}, 32'h0);
    end

    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      drive(tbl[v].stall, tbl[v].i0, tbl[v].i1, tbl[v].iv, tbl[v].ird,
            tbl[v].wv, tbl[v].wrd, tbl[v].wd);
      #1;
      n_vec++;
      chk("data0", v, rs_data[31:0], tbl[v].ed0);
      chk("busy0", v, {31'h0, rs_busy[0]}, {31'h0, tbl[v].eb0});
      chk("data1", v, rs_data[63:32], tbl[v].ed1);
      chk("busy1", v, {31'h0, rs_busy[1]}, {31'h0, tbl[v].eb1});
      chk("cnt", v, {26'h0, busy_count}, {26'h0, tbl[v].ecnt});
    end

    // Fill the scoreboard x1..x31; busy_count should climb by one per edge.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 5'd0, 1'b1, 5'(i), 1'b0, 5'd0, 32'h0);
      #1;
      n_vec++;
      chk("fill_cnt", i, {26'h0, busy_count}, i - 1);
    end
    @(negedge clk);
    drive(1'b0, 5'd9, 5'd31, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    #1;
    n_vec++;
    chk("full_cnt", 0, {26'h0, busy_count}, 32'd31);
    chk("full_busy", 0, {30'h0, rs_busy}, 32'h3);

    // Reset must override a simultaneous wb, issue and stall.
    reset = 1'b1;
    drive(1'b1, 5'd9, 5'd5, 1'b1, 5'd9, 1'b1, 5'd9, 32'h99);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 5'd9, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    #1;
    n_vec++;
    chk("post_rst_data9", 0, rs_data[31:0], 32'h0);
    chk("post_rst_data5", 0, rs_data[63:32], 32'h0);
    chk("post_rst_busy", 0, {30'h0, rs_busy}, 32'h0);
    chk("post_rst_cnt", 0, {26'h0, busy_count}, 32'h0);

    // Writes resume normally after reset.
    drive(1'b0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'hCAFE0009);
    @(negedge clk);
    idle();
    rs_idx = {5'd0, 5'd9};
    #1;
    n_vec++;
    chk("resume_data9", 0, rs_data[31:0], 32'hCAFE0009);
    chk("resume_cnt", 0, {26'h0, busy_count}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
